// File: rtl/nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// nonrestoring_divider
//
// Sequential unsigned divider using the non-restoring algorithm. One quotient
// bit is produced per clock; a final FIX cycle corrects a negative partial
// remainder.
//
// Timeline for a start accepted at edge T:
//   cycles T+1 .. T+WIDTH : CALC (one iteration per cycle)
//   cycle  T+WIDTH+1      : FIX  (remainder correction)
//   cycle  T+WIDTH+2      : DONE (done pulses, results valid)
// The next start can be accepted at the edge that ends the DONE cycle's
// successor (IDLE), giving one division per WIDTH+3 cycles back to back.
//
// Optional feature macro: DIV_ZERO_CHECK_EN
//   defined   : a zero divisor is detected at accept time and the divider
//               jumps straight to DONE (done at T+1, div_by_zero=1).
//   undefined : no detection logic; a zero divisor runs the normal sequence
//               and naturally yields quotient=all ones, remainder=dividend;
//               div_by_zero is tied low.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset (priority over start)
//   start        in   division request, sampled only in IDLE
//   dividend     in   WIDTH-bit unsigned dividend, captured on accept
//   divisor      in   WIDTH-bit unsigned divisor, captured on accept
//   busy         out  high while in CALC or FIX
//   done         out  one-cycle pulse when results become valid
//   quotient     out  registered WIDTH-bit quotient
//   remainder    out  registered WIDTH-bit remainder
//   div_by_zero  out  registered divide-by-zero flag
// -----------------------------------------------------------------------------
module nonrestoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic signed [WIDTH:0]   r_p;     // partial remainder, two's complement
  logic [WIDTH-1:0]        r_aq;    // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0]        r_d;     // captured divisor
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic [WIDTH-1:0]        r_quo;
  logic [WIDTH-1:0]        r_rem;

  logic signed [WIDTH:0]   w_shift;
  logic signed [WIDTH:0]   w_step;
  logic signed [WIDTH:0]   w_fix;
  logic [WIDTH:0]          w_dext;

  // Single WIDTH+1-bit adder: sub=1 inverts the operand and injects carry-in,
  // so the same hardware performs a+b or a-b.
  function automatic logic signed [WIDTH:0] addsub(
    input logic signed [WIDTH:0] a,
    input logic [WIDTH:0]        b,
    input logic                  sub
  );
    logic [WIDTH:0] b_m;
    logic [WIDTH:0] sum;
    b_m = b ^ {(WIDTH+1){sub}};
    sum = $unsigned(a) + b_m + {{WIDTH{1'b0}}, sub};
    return $signed(sum);
  endfunction

  assign w_dext  = {1'b0, r_d};
  // Shift the next dividend bit into P; the MSB lost here is recovered by
  // modular arithmetic because the add/sub result always fits in range.
  assign w_shift = $signed({r_p[WIDTH-1:0], r_aq[WIDTH-1]});
  // Sign of the previous P chooses subtract (P>=0) or add (P<0).
  assign w_step  = addsub(w_shift, w_dext, ~r_p[WIDTH]);
  assign w_fix   = r_p[WIDTH] ? addsub(r_p, w_dext, 1'b0) : r_p;

`ifdef DIV_ZERO_CHECK_EN
  logic r_dbz;
  logic w_zero;
  assign w_zero      = (divisor == '0);
  assign div_by_zero = r_dbz;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_aq    <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
`ifdef DIV_ZERO_CHECK_EN
      r_dbz   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_d   <= divisor;
            r_aq  <= dividend;
            r_p   <= '0;
            r_cnt <= CNT_W'(WIDTH);
`ifdef DIV_ZERO_CHECK_EN
            if (w_zero) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quo   <= '1;
              r_rem   <= dividend;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
`else
            r_state <= S_CALC;
            r_busy  <= 1'b1;
`endif
          end
        end

        S_CALC: begin
          r_p   <= w_step;
          // Quotient bit is the inverted sign of the new partial remainder.
          r_aq  <= {r_aq[WIDTH-2:0], ~w_step[WIDTH]};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          r_p     <= w_fix;
          r_quo   <= r_aq;
          r_rem   <= w_fix[WIDTH-1:0];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
`ifdef DIV_ZERO_CHECK_EN
          r_dbz   <= 1'b0;
`endif
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: tb/tb_nonrestoring_divider.sv
module tb_nonrestoring_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s8, s16;
  logic [7:0]  dd8, dv8, q8, r8;
  logic [15:0] dd16, dv16, q16, r16;
  logic        b8, d8, z8, b16, d16, z16;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  nonrestoring_divider #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .dividend(dd8), .divisor(dv8),
    .busy(b8), .done(d8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
  );

  nonrestoring_divider #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(s16), .dividend(dd16), .divisor(dv16),
    .busy(b16), .done(d16), .quotient(q16), .remainder(r16), .div_by_zero(z16)
  );

  // Reference model: plain integer division, with the zero-divisor result
  // defined as quotient = all ones, remainder = dividend.
  function automatic logic [15:0] ref_q(input int w, input logic [15:0] a, input logic [15:0] b);
    if (b == 16'd0) return (w == 8) ? 16'h00FF : 16'hFFFF;
    return a / b;
  endfunction

  function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'd0) return a;
    return a % b;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample(input int w, output logic bz, output logic dn, output logic dz,
                        output logic [15:0] q, output logic [15:0] r);
    if (w == 8) begin
      bz = b8; dn = d8; dz = z8; q = {8'h00, q8}; r = {8'h00, r8};
    end else begin
      bz = b16; dn = d16; dz = z16; q = q16; r = r16;
    end
  endtask

  // Issues one division and waits (bounded) for done. cyc is the cycle index
  // at which done was seen, counting the cycle after the accept edge as 1.
  // berr counts cycles where busy differed from its expected waveform.
  // dlow reports whether done dropped again on the following cycle.
  task automatic do_div(input int w, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r, output logic dz,
                        output int cyc, output int berr, output logic dlow);
    logic bz, dn, fast;
    logic [15:0] tq, tr;
    fast = ZCHK && (b == 16'd0);
    berr = 0;
    if (w == 8) begin s8 = 1'b1; dd8 = a[7:0]; dv8 = b[7:0]; end
    else        begin s16 = 1'b1; dd16 = a; dv16 = b; end
    step();
    s8 = 1'b0; s16 = 1'b0;
    cyc = 1;
    while (1) begin
      sample(w, bz, dn, dz, q, r);
      if (bz !== ((!fast) && (cyc <= w + 1))) berr++;
      if (dn === 1'b1 || cyc >= 60) break;
      step();
      cyc++;
    end
    step();
    sample(w, bz, dn, dz, tq, tr);
    dlow = (dn === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; s8 = 0; s16 = 0; dd8 = 0; dv8 = 0; dd16 = 0; dv16 = 0;
    step(); step();
    rst = 1'b0;
    n_cmp++; if ({b8, d8, z8} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl8 got %b want 000", {b8, d8, z8}); end
    n_cmp++; if ({q8, r8} !== 16'h0000) begin n_fail++; $display("FAIL reset_data8 got %h want 0000", {q8, r8}); end
    n_cmp++; if ({b16, d16, z16} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl16 got %b want 000", {b16, d16, z16}); end
    n_cmp++; if ({q16, r16} !== 32'h0) begin n_fail++; $display("FAIL reset_data16 got %h want 0", {q16, r16}); end
  endtask

  task automatic test_directed();
    logic [15:0] ta [4] = '{16'd100, 16'd255, 16'd5, 16'd13};
    logic [15:0] tb [4] = '{16'd7,   16'd1,   16'd9, 16'd0};
    logic [15:0] q, r;
    logic dz, dlow;
    int cyc, berr, ecyc;
    for (int i = 0; i < 4; i++) begin
      do_div(8, ta[i], tb[i], q, r, dz, cyc, berr, dlow);
      ecyc = (ZCHK && tb[i] == 0) ? 1 : 10;
      n_cmp++; if (q !== ref_q(8, ta[i], tb[i])) begin n_fail++; $display("FAIL dir_quot %0d/%0d got %0d want %0d", ta[i], tb[i], q, ref_q(8, ta[i], tb[i])); end
      n_cmp++; if (r !== ref_r(ta[i], tb[i])) begin n_fail++; $display("FAIL dir_rem %0d/%0d got %0d want %0d", ta[i], tb[i], r, ref_r(ta[i], tb[i])); end
      n_cmp++; if (dz !== (ZCHK && tb[i] == 0)) begin n_fail++; $display("FAIL dir_dbz %0d/%0d got %b want %b", ta[i], tb[i], dz, (ZCHK && tb[i] == 0)); end
      n_cmp++; if (cyc != ecyc) begin n_fail++; $display("FAIL dir_latency %0d/%0d got %0d want %0d", ta[i], tb[i], cyc, ecyc); end
      n_cmp++; if (berr != 0) begin n_fail++; $display("FAIL dir_busy %0d/%0d got %0d bad cycles want 0", ta[i], tb[i], berr); end
      n_cmp++; if (!dlow) begin n_fail++; $display("FAIL dir_done_pulse %0d/%0d done still high want low", ta[i], tb[i]); end
    end
  endtask

  task automatic test_hold();
    logic [15:0] q, r;
    logic dz, dlow;
    int cyc, berr, bad;
    do_div(8, 16'd200, 16'd9, q, r, dz, cyc, berr, dlow);
    bad = 0;
    dd8 = 8'd1; dv8 = 8'd1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (q8 !== 8'd22 || r8 !== 8'd2 || d8 !== 1'b0 || b8 !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL hold got %0d bad cycles (q=%0d r=%0d) want 0 (22 r 2)", bad, q8, r8); end
  endtask

  task automatic test_ignore();
    int cyc;
    s8 = 1'b1; dd8 = 8'd100; dv8 = 8'd7;
    step();
    s8 = 1'b0;
    cyc = 1;
    while (d8 !== 1'b1 && cyc < 60) begin
      if (cyc >= 2 && cyc <= 6) begin s8 = 1'b1; dd8 = 8'($urandom); dv8 = 8'($urandom_range(1, 255)); end
      else s8 = 1'b0;
      step();
      cyc++;
    end
    s8 = 1'b0;
    n_cmp++; if (cyc != 10) begin n_fail++; $display("FAIL ignore_latency got %0d want 10", cyc); end
    n_cmp++; if (q8 !== 8'd14 || r8 !== 8'd2) begin n_fail++; $display("FAIL ignore_result got %0d r %0d want 14 r 2", q8, r8); end
    step(); step();
  endtask

  task automatic test_reset_mid();
    logic [15:0] q, r;
    logic dz, dlow;
    int cyc, berr, seen;
    s8 = 1'b1; dd8 = 8'd100; dv8 = 8'd7;
    step();
    s8 = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({b8, d8, z8, q8, r8} !== 19'd0) begin n_fail++; $display("FAIL midreset_outputs got b=%b d=%b z=%b q=%0d r=%0d want all 0", b8, d8, z8, q8, r8); end
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      if (d8 === 1'b1 || b8 === 1'b1) seen++;
      step();
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL midreset_no_done got %0d active cycles want 0", seen); end
    do_div(8, 16'd200, 16'd3, q, r, dz, cyc, berr, dlow);
    n_cmp++; if (q !== 16'd66 || r !== 16'd2) begin n_fail++; $display("FAIL midreset_next got %0d r %0d want 66 r 2", q, r); end
    n_cmp++; if (cyc != 10) begin n_fail++; $display("FAIL midreset_next_latency got %0d want 10", cyc); end
  endtask

  task automatic test_back_to_back();
    int t, first, second;
    first = -1; second = -1;
    s16 = 1'b1; dd16 = 16'd50000; dv16 = 16'd7;
    for (t = 0; t < 80 && second < 0; t++) begin
      step();
      if (d16 === 1'b1) begin
        if (first < 0) first = t; else second = t;
      end
    end
    s16 = 1'b0;
    n_cmp++; if (second - first != 19) begin n_fail++; $display("FAIL b2b_period got %0d want 19", second - first); end
    n_cmp++; if (q16 !== 16'd7142 || r16 !== 16'd6) begin n_fail++; $display("FAIL b2b_result got %0d r %0d want 7142 r 6", q16, r16); end
    for (int i = 0; i < 25; i++) step();
  endtask

  task automatic test_random16();
    logic [15:0] a, b, q, r;
    logic dz, dlow;
    int cyc, berr;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      do_div(16, a, b, q, r, dz, cyc, berr, dlow);
      n_cmp++; if (q !== a / b || r !== a % b) begin n_fail++; $display("FAIL rand_result %0d/%0d got %0d r %0d want %0d r %0d", a, b, q, r, a / b, a % b); end
      n_cmp++; if (cyc != 18) begin n_fail++; $display("FAIL rand_latency %0d/%0d got %0d want 18", a, b, cyc); end
      n_cmp++; if (berr != 0 || dz !== 1'b0 || !dlow) begin n_fail++; $display("FAIL rand_ctl %0d/%0d busy_err=%0d dbz=%b done_low=%b want 0/0/1", a, b, berr, dz, dlow); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
